// File: rtl/rs_param_issue_queue.sv
// rs_param_issue_queue: parametrised reservation station with CDB wakeup/bypass and a registered valid/ready issue port.
// Define RS_AGE_SELECT_EN to issue the oldest eligible entry instead of the lowest-index one.
module rs_param_issue_queue #(
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int OP_W    = 7,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_data,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [XLEN-1:0]            disp_pc,
  input  logic [XLEN-1:0]            disp_imm,
  input  logic [XLEN-1:0]            disp_vi,
  input  logic [XLEN-1:0]            disp_vj,
  input  logic [TAG_W-1:0]           disp_qi,
  input  logic [TAG_W-1:0]           disp_qj,
  input  logic [TAG_W-1:0]           disp_rob_id,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [XLEN-1:0]            iss_vi,
  output logic [XLEN-1:0]            iss_vj,
  output logic [XLEN-1:0]            iss_imm,
  output logic [XLEN-1:0]            iss_pc,
  output logic [TAG_W-1:0]           iss_rob_id,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] valid, elig;
  logic [OP_W-1:0]  op  [DEPTH];
  logic [XLEN-1:0]  pc  [DEPTH];
  logic [XLEN-1:0]  imm [DEPTH];
  logic [XLEN-1:0]  vi  [DEPTH];
  logic [XLEN-1:0]  vj  [DEPTH];
  logic [TAG_W-1:0] qi  [DEPTH];
  logic [TAG_W-1:0] qj  [DEPTH];
  logic [TAG_W-1:0] rob [DEPTH];
  logic [XLEN-1:0]  nvi [DEPTH];
  logic [XLEN-1:0]  nvj [DEPTH];
  logic [TAG_W-1:0] nqi [DEPTH];
  logic [TAG_W-1:0] nqj [DEPTH];
  logic [XLEN-1:0]  dvi, dvj;
  logic [TAG_W-1:0] dqi, dqj;
  logic [IW-1:0]    free_idx, sel;
  logic             any_elig, load, dispatch;
`ifdef RS_AGE_SELECT_EN
  logic [IW-1:0]    age [DEPTH];
`endif
  assign disp_ready = count != CW'(DEPTH);
  assign dispatch   = disp_valid && disp_ready;
  assign load       = (!iss_valid || iss_ready) && any_elig;
  for (genvar i = 0; i < DEPTH; i++) begin : g_elig
    assign elig[i] = valid[i] && qi[i] == '0 && qj[i] == '0;
  end
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) if (!valid[i]) free_idx = IW'(i);
  end
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_AGE_SELECT_EN
      if (elig[i] && (!any_elig || age[i] < age[sel])) begin
`else
      if (elig[i] && !any_elig) begin
`endif
        sel      = IW'(i);
        any_elig = 1'b1;
      end
    end
  end
  // Buses scanned high to low so the lowest-index matching bus overrides.
  always_comb begin
    dqi = disp_qi;
    dvi = disp_vi;
    dqj = disp_qj;
    dvj = disp_vj;
    for (int i = 0; i < DEPTH; i++) begin
      nqi[i] = qi[i];
      nvi[i] = vi[i];
      nqj[i] = qj[i];
      nvj[i] = vj[i];
    end
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] != '0) begin
        if (disp_qi == cdb_tag[k*TAG_W +: TAG_W]) begin
          dqi = '0;
          dvi = cdb_data[k*XLEN +: XLEN];
        end
        if (disp_qj == cdb_tag[k*TAG_W +: TAG_W]) begin
          dqj = '0;
          dvj = cdb_data[k*XLEN +: XLEN];
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (qi[i] == cdb_tag[k*TAG_W +: TAG_W]) begin
            nqi[i] = '0;
            nvi[i] = cdb_data[k*XLEN +: XLEN];
          end
          if (qj[i] == cdb_tag[k*TAG_W +: TAG_W]) begin
            nqj[i] = '0;
            nvj[i] = cdb_data[k*XLEN +: XLEN];
          end
        end
      end
    end
  end
  // Entry payload needs no reset: it is only observed through valid.
  always_ff @(posedge clk)
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        qi[i] <= nqi[i];
        vi[i] <= nvi[i];
        qj[i] <= nqj[i];
        vj[i] <= nvj[i];
      end
      if (dispatch) begin
        op[free_idx]  <= disp_op;
        pc[free_idx]  <= disp_pc;
        imm[free_idx] <= disp_imm;
        rob[free_idx] <= disp_rob_id;
        qi[free_idx]  <= dqi;
        vi[free_idx]  <= dvi;
        qj[free_idx]  <= dqj;
        vj[free_idx]  <= dvj;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid      <= '0;
      count      <= '0;
      iss_valid  <= 1'b0;
      iss_op     <= '0;
      iss_vi     <= '0;
      iss_vj     <= '0;
      iss_imm    <= '0;
      iss_pc     <= '0;
      iss_rob_id <= '0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
`endif
    end else if (flush) begin
      valid      <= '0;
      count      <= '0;
      iss_valid  <= 1'b0;
      iss_op     <= '0;
      iss_vi     <= '0;
      iss_vj     <= '0;
      iss_imm    <= '0;
      iss_pc     <= '0;
      iss_rob_id <= '0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
`endif
    end else if (rdy) begin
      if (load) begin
        iss_valid  <= 1'b1;
        iss_op     <= op[sel];
        iss_vi     <= vi[sel];
        iss_vj     <= vj[sel];
        iss_imm    <= imm[sel];
        iss_pc     <= pc[sel];
        iss_rob_id <= rob[sel];
      end else if (!iss_valid || iss_ready) iss_valid <= 1'b0;
      valid <= (valid & ~(DEPTH'(load) << sel)) | (DEPTH'(dispatch) << free_idx);
      count <= count + CW'(dispatch) - CW'(load);
`ifdef RS_AGE_SELECT_EN
      // Ages of valid entries stay a dense 0..count-1 ranking, 0 being oldest.
      for (int i = 0; i < DEPTH; i++) if (load && age[i] > age[sel]) age[i] <= age[i] - 1'b1;
      if (dispatch) age[free_idx] <= IW'(count - CW'(load));
`endif
    end
endmodule

// File: tb/tb_rs_param_issue_queue.sv
// tb_rs_param_issue_queue: directed scenario tests for rs_param_issue_queue at default parameters.
module tb_rs_param_issue_queue;
  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        disp_valid, disp_ready;
  logic [6:0]  disp_op;
  logic [31:0] disp_pc, disp_imm, disp_vi, disp_vj;
  logic [4:0]  disp_qi, disp_qj, disp_rob_id;
  logic        iss_valid, iss_ready;
  logic [6:0]  iss_op;
  logic [31:0] iss_vi, iss_vj, iss_imm, iss_pc;
  logic [4:0]  iss_rob_id;
  logic [4:0]  count;
  int          nvec = 0;
  int          nerr = 0;

  rs_param_issue_queue dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_vi(disp_vi), .disp_vj(disp_vj),
    .disp_qi(disp_qi), .disp_qj(disp_qj), .disp_rob_id(disp_rob_id),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_vi(iss_vi), .iss_vj(iss_vj), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_rob_id(iss_rob_id), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] qi, input logic [4:0] qj,
                       input logic [31:0] vi, input logic [31:0] vj, input logic [4:0] rob);
    disp_valid = 1'b1; disp_op = op; disp_qi = qi; disp_qj = qj;
    disp_vi = vi; disp_vj = vj; disp_rob_id = rob;
    disp_pc = 32'h1000 + 32'(rob); disp_imm = 32'h100 + 32'(rob);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    disp_valid = 1'b0; iss_ready = 1'b1;
    drive(7'h0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    disp_valid = 1'b0;
    tick; tick;
    nvec++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL reset_iss_valid got %0b want 0", iss_valid); end
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count); end
    nvec++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL reset_disp_ready got %0b want 1", disp_ready); end
    nvec++; if ({iss_op, iss_vi, iss_vj, iss_imm, iss_pc, iss_rob_id} !== '0) begin nerr++; $display("FAIL reset_iss_data got nonzero vi=%h rob=%0d want 0", iss_vi, iss_rob_id); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    iss_ready = 1'b1;
    drive(7'h33, 5'd0, 5'd0, 32'd5, 32'd7, 5'd3);
    tick;
    disp_valid = 1'b0;
    nvec++; if (count !== 5'd1) begin nerr++; $display("FAIL basic_count1 got %0d want 1", count); end
    nvec++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL basic_early got %0b want 0", iss_valid); end
    tick;
    nvec++; if (iss_valid !== 1'b1) begin nerr++; $display("FAIL basic_valid got %0b want 1", iss_valid); end
    nvec++; if ({iss_op, iss_vi, iss_vj, iss_rob_id} !== {7'h33, 32'd5, 32'd7, 5'd3}) begin nerr++; $display("FAIL basic_data got op=%h vi=%0d vj=%0d rob=%0d want 33/5/7/3", iss_op, iss_vi, iss_vj, iss_rob_id); end
    nvec++; if ({iss_pc, iss_imm} !== {32'h1003, 32'h103}) begin nerr++; $display("FAIL basic_pc_imm got %h/%h want 1003/103", iss_pc, iss_imm); end
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL basic_count0 got %0d want 0", count); end
    tick;
    nvec++; if (iss_valid !== 1'b0 || iss_vi !== 32'd5) begin nerr++; $display("FAIL basic_idle got valid=%0b vi=%0d want 0/5", iss_valid, iss_vi); end
  endtask

  task automatic test_wakeup;
    drive(7'h13, 5'd4, 5'd0, 32'd0, 32'd1, 5'd5);
    tick;
    disp_valid = 1'b0;
    tick;
    nvec++; if (iss_valid !== 1'b0 || count !== 5'd1) begin nerr++; $display("FAIL wake_waiting got valid=%0b count=%0d want 0/1", iss_valid, count); end
    cdb_valid = 2'b10; cdb_tag = {5'd4, 5'd4}; cdb_data = {32'hDEAD, 32'h1111};
    tick;
    cdb_valid = '0;
    nvec++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL wake_latency got %0b want 0", iss_valid); end
    tick;
    nvec++; if (iss_valid !== 1'b1 || iss_vi !== 32'hDEAD || iss_rob_id !== 5'd5) begin nerr++; $display("FAIL wake_issue got valid=%0b vi=%h rob=%0d want 1/dead/5", iss_valid, iss_vi, iss_rob_id); end
    tick;
  endtask

  task automatic test_bypass;
    drive(7'h23, 5'd0, 5'd6, 32'd2, 32'd0, 5'd8);
    cdb_valid = 2'b11; cdb_tag = {5'd0, 5'd6}; cdb_data = {32'd99, 32'd9};
    tick;
    disp_valid = 1'b0; cdb_valid = '0;
    tick;
    nvec++; if (iss_valid !== 1'b1 || iss_vj !== 32'd9 || iss_vi !== 32'd2) begin nerr++; $display("FAIL bypass got valid=%0b vi=%0d vj=%0d want 1/2/9", iss_valid, iss_vi, iss_vj); end
    tick;
  endtask

  task automatic test_bus_priority;
    drive(7'h03, 5'd8, 5'd0, 32'd0, 32'd4, 5'd9);
    tick;
    disp_valid = 1'b0;
    cdb_valid = 2'b11; cdb_tag = {5'd8, 5'd8}; cdb_data = {32'hB, 32'hA};
    tick;
    cdb_valid = '0;
    tick;
    nvec++; if (iss_valid !== 1'b1 || iss_vi !== 32'hA) begin nerr++; $display("FAIL bus_priority got valid=%0b vi=%h want 1/a", iss_valid, iss_vi); end
    tick;
  endtask

  task automatic test_backpressure;
    iss_ready = 1'b0;
    drive(7'h33, 5'd0, 5'd0, 32'd11, 32'd0, 5'd10);
    tick;
    drive(7'h33, 5'd0, 5'd0, 32'd12, 32'd0, 5'd11);
    tick;
    disp_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      nvec++; if (iss_valid !== 1'b1 || iss_rob_id !== 5'd10 || iss_vi !== 32'd11 || count !== 5'd1) begin nerr++; $display("FAIL backpressure_hold%0d got valid=%0b rob=%0d vi=%0d count=%0d want 1/10/11/1", c, iss_valid, iss_rob_id, iss_vi, count); end
      tick;
    end
    iss_ready = 1'b1;
    tick;
    nvec++; if (iss_valid !== 1'b1 || iss_rob_id !== 5'd11 || iss_vi !== 32'd12 || count !== 5'd0) begin nerr++; $display("FAIL backpressure_release got valid=%0b rob=%0d vi=%0d count=%0d want 1/11/12/0", iss_valid, iss_rob_id, iss_vi, count); end
    tick;
    nvec++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL backpressure_empty got %0b want 0", iss_valid); end
  endtask

  task automatic test_full;
    iss_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(7'h33, 5'd7, 5'd0, 32'd0, 32'(i), 5'(i + 1));
      tick;
    end
    drive(7'h33, 5'd0, 5'd0, 32'd1, 32'd1, 5'd20);
    nvec++; if (count !== 5'd16 || disp_ready !== 1'b0) begin nerr++; $display("FAIL full got count=%0d ready=%0b want 16/0", count, disp_ready); end
    tick;
    nvec++; if (count !== 5'd16) begin nerr++; $display("FAIL full_refuse got count=%0d want 16", count); end
    cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd7}; cdb_data = {32'd0, 32'h77};
    tick;
    cdb_valid = '0;
    nvec++; if (count !== 5'd16 || iss_valid !== 1'b0) begin nerr++; $display("FAIL full_wake got count=%0d valid=%0b want 16/0", count, iss_valid); end
    tick;
    disp_valid = 1'b0;
    nvec++; if (iss_valid !== 1'b1 || iss_rob_id !== 5'd1 || iss_vi !== 32'h77 || count !== 5'd15 || disp_ready !== 1'b1) begin nerr++; $display("FAIL full_first got valid=%0b rob=%0d vi=%h count=%0d ready=%0b want 1/1/77/15/1", iss_valid, iss_rob_id, iss_vi, count, disp_ready); end
    for (int j = 2; j <= 16; j++) begin
      tick;
      nvec++; if (iss_valid !== 1'b1 || iss_rob_id !== 5'(j) || iss_vj !== 32'(j - 1) || count !== 5'(16 - j)) begin nerr++; $display("FAIL full_drain%0d got rob=%0d vj=%0d count=%0d want %0d/%0d/%0d", j, iss_rob_id, iss_vj, count, j, j - 1, 16 - j); end
    end
    tick;
    nvec++; if (iss_valid !== 1'b0 || count !== 5'd0) begin nerr++; $display("FAIL full_empty got valid=%0b count=%0d want 0/0", iss_valid, count); end
  endtask

  task automatic test_rdy_hold;
    rdy = 1'b0;
    drive(7'h33, 5'd0, 5'd0, 32'd1, 32'd1, 5'd12);
    tick;
    disp_valid = 1'b0; rdy = 1'b1;
    nvec++; if (count !== 5'd0 || iss_valid !== 1'b0) begin nerr++; $display("FAIL rdy_hold got count=%0d valid=%0b want 0/0", count, iss_valid); end
  endtask

  task automatic test_flush;
    iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(7'h33, 5'd0, 5'd0, 32'(i + 40), 32'd0, 5'(i + 1));
      tick;
    end
    disp_valid = 1'b0;
    nvec++; if (count !== 5'd5 || iss_valid !== 1'b1) begin nerr++; $display("FAIL flush_pre got count=%0d valid=%0b want 5/1", count, iss_valid); end
    flush = 1'b1;
    drive(7'h33, 5'd0, 5'd0, 32'd3, 32'd3, 5'd13);
    tick;
    flush = 1'b0; disp_valid = 1'b0;
    nvec++; if (count !== 5'd0 || iss_valid !== 1'b0 || iss_vi !== 32'd0 || iss_rob_id !== 5'd0 || disp_ready !== 1'b1) begin nerr++; $display("FAIL flush got count=%0d valid=%0b vi=%0d rob=%0d ready=%0b want 0/0/0/0/1", count, iss_valid, iss_vi, iss_rob_id, disp_ready); end
    iss_ready = 1'b1;
    tick;
    nvec++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL flush_after got %0b want 0", iss_valid); end
  endtask

  task automatic test_async_reset;
    iss_ready = 1'b0;
    drive(7'h33, 5'd0, 5'd0, 32'h55, 32'd0, 5'd9);
    tick;
    drive(7'h33, 5'd0, 5'd0, 32'h66, 32'd0, 5'd10);
    tick;
    disp_valid = 1'b0;
    nvec++; if (iss_valid !== 1'b1 || iss_vi !== 32'h55 || count !== 5'd1) begin nerr++; $display("FAIL areset_pre got valid=%0b vi=%h count=%0d want 1/55/1", iss_valid, iss_vi, count); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (iss_valid !== 1'b0 || iss_vi !== 32'd0 || count !== 5'd0) begin nerr++; $display("FAIL areset got valid=%0b vi=%h count=%0d want 0/0/0", iss_valid, iss_vi, count); end
    #1 rst_n = 1'b1;
    iss_ready = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wakeup;
    test_bypass;
    test_bus_priority;
    test_backpressure;
    test_full;
    test_rdy_hold;
    test_flush;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
